// File: rtl/hex_pkg.sv
// Shared definitions for the hex display: segment patterns and scan FSM states.
package hex_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Active-low 7-segment patterns, bit 0 = segment a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_7seg.sv
// Combinational 4-bit hex nibble to active-low 7-segment decoder.
module hex_7seg
  import hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one nibble.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display.sv
// Multi-digit hex display: captures a value, then decodes one digit per clock
// (MSB first) through a single shared decoder, with optional leading-zero
// blanking and a per-digit blink overlay.
module hex_display
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_blank_lz,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("hex_display: NUM_DIGITS must be in 1..8");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("hex_display: BLINK_DIV must be >= 1");
  end

  localparam int             CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [2:0]     LAST_IDX = 3'(NUM_DIGITS - 1);

  state_t                         state_q;
  state_t                         state_d;
  logic                           accept;
  logic                           scan_we;
  logic [2:0]                     idx_q;
  logic [4*NUM_DIGITS-1:0]        shadow_q;
  logic                           lz_q;
  logic [NUM_DIGITS-1:0][6:0]     seg_q;
  logic [3:0]                     cur_nib;
  logic [6:0]                     dec_seg;
  logic [6:0]                     wr_seg;
  logic                           wr_blank;
  logic [CNT_W-1:0]               blink_cnt;
  logic                           blink_phase;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, handshake and scan write enable.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    accept     = 1'b0;
    scan_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = ~rst;
        if (load_valid && !rst) begin
          accept  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_we = 1'b1;
        if (idx_q == 3'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the nibble addressed by the scan index for the shared decoder.
  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) cur_nib = shadow_q[4*i +: 4];
    end
  end

  hex_7seg u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // A digit is blanked while every digit above it has been zero; digit 0 always shows.
  assign wr_blank = lz_q && (cur_nib == 4'h0) && (idx_q != 3'd0);
  assign wr_seg   = wr_blank ? SEG_BLANK : dec_seg;

  // Shadow capture, scan index and running leading-zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= LAST_IDX;
      shadow_q <= '0;
      lz_q     <= 1'b0;
    end else if (accept) begin
      idx_q    <= LAST_IDX;
      shadow_q <= load_data;
      lz_q     <= load_blank_lz;
    end else if (scan_we) begin
      idx_q    <= (idx_q == 3'd0) ? LAST_IDX : idx_q - 3'd1;
      lz_q     <= wr_blank;
    end
  end

  // Per-digit segment registers; only the addressed digit changes during a scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= {NUM_DIGITS{SEG_BLANK}};
    end else if (scan_we) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == 3'(i)) seg_q[i] <= wr_seg;
      end
    end
  end

  // Free-running blink divider; phase toggles on every wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Blink overlay forces enabled digits dark during the blink phase.
  always_comb begin
    hex_out = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_out[7*i +: 7] = seg_q[i] | ((blink_phase && blink_en[i]) ? SEG_BLANK : 7'h00);
    end
  end

endmodule

// File: tb/tb_hex_display.sv
// Self-checking bench for hex_display (4 digits, blink half-period 4 cycles).
module tb_hex_display;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [15:0]   load_data;
  logic          load_blank_lz;
  logic          load_ready;
  logic [3:0]    blink_en;
  logic [27:0]   hex_out;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: edges since reset, acceptance edge, old and new display.
  int         e     = 0;
  int         t_acc = -100;
  logic [6:0] prev_d [N];
  logic [6:0] tgt_d  [N];

  hex_display #(.NUM_DIGITS(N), .BLINK_DIV(DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_blank_lz (load_blank_lz),
    .load_ready    (load_ready),
    .blink_en      (blink_en),
    .hex_out       (hex_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] target_of(input logic [15:0] v, input logic blz, input int i);
    logic [15:0] hi;
    hi = v >> (4 * i);
    if (blz && i > 0 && hi == 16'h0) return 7'h7F;
    return seg_tab[hi[3:0]];
  endfunction

  function automatic logic m_ready();
    return (e >= t_acc + N);
  endfunction

  function automatic logic [6:0] m_digit(input int i);
    return (e >= t_acc + N - i) ? tgt_d[i] : prev_d[i];
  endfunction

  function automatic logic [27:0] exp_hex();
    logic [27:0] r;
    logic        ph;
    r  = '0;
    ph = ((e / DIV) % 2) == 1;
    for (int i = 0; i < N; i++)
      r[7*i +: 7] = m_digit(i) | ((ph && blink_en[i]) ? 7'h7F : 7'h00);
    return r;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      e     = 0;
      t_acc = -100;
      for (int i = 0; i < N; i++) begin
        prev_d[i] = 7'h7F;
        tgt_d[i]  = 7'h7F;
      end
    end else begin
      if (load_valid && m_ready()) begin
        for (int i = 0; i < N; i++) begin
          prev_d[i] = m_digit(i);
          tgt_d[i]  = target_of(load_data, load_blank_lz, i);
        end
        t_acc = e + 1;
      end
      e = e + 1;
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (load_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL %s_ready_timeout: load_ready=%b want 1", nm, load_ready);
    end
  endtask

  // Offer one value and return in the cycle after the accepting edge.
  task automatic load_one(input logic [15:0] v, input logic blz, input string nm);
    wait_ready(nm);
    load_valid    = 1'b1;
    load_data     = v;
    load_blank_lz = blz;
    @(negedge clk);
    load_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; blink_en = 4'hF; load_valid = 1'b0;
    @(negedge clk);
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low: got %b want 0", load_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", load_ready); end
    total++;
    if (hex_out !== 28'hFFFFFFF) begin bad++; $display("FAIL rst_blank: got %h want fffffff", hex_out); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (hex_out !== exp_hex()) begin bad++; $display("FAIL rst_hold: got %h want %h", hex_out, exp_hex()); end
    end
    blink_en = 4'h0;
  endtask

  task automatic test_load_basic();
    load_one(16'h12AF, 1'b0, "basic");
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (load_ready !== 1'b0) begin bad++; $display("FAIL basic_busy_c%0d: got %b want 0", k, load_ready); end
      total++;
      if (hex_out !== exp_hex()) begin bad++; $display("FAIL basic_scan_c%0d: got %h want %h", k, hex_out, exp_hex()); end
      if (k == 2) begin
        total++;
        if (hex_out[27:21] !== 7'h79) begin bad++; $display("FAIL basic_d3_early: got %h want 79", hex_out[27:21]); end
      end
      @(negedge clk);
    end
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", load_ready); end
    total++;
    if (hex_out !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin
      bad++; $display("FAIL basic_final: got %h want %h", hex_out, {7'h79, 7'h24, 7'h08, 7'h0E});
    end
  endtask

  task automatic test_leading_zero();
    load_one(16'h0050, 1'b1, "lz1");
    repeat (N) @(negedge clk);
    total++;
    if (hex_out !== {7'h7F, 7'h7F, 7'h12, 7'h40}) begin
      bad++; $display("FAIL lz_0050: got %h want %h", hex_out, {7'h7F, 7'h7F, 7'h12, 7'h40});
    end
    load_one(16'h0000, 1'b1, "lz2");
    repeat (N) @(negedge clk);
    total++;
    if (hex_out !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      bad++; $display("FAIL lz_0000: got %h want %h", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
    total++;
    if (hex_out !== exp_hex()) begin bad++; $display("FAIL lz_model: got %h want %h", hex_out, exp_hex()); end
  endtask

  task automatic test_blink();
    int         run;
    int         changes;
    logic [6:0] last;
    load_one(16'h1234, 1'b0, "blink");
    repeat (N) @(negedge clk);
    blink_en = 4'b0001;
    #1;
    last = hex_out[6:0]; run = 0; changes = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      total++;
      if (hex_out !== exp_hex()) begin bad++; $display("FAIL blink_model_c%0d: got %h want %h", k, hex_out, exp_hex()); end
      total++;
      if (hex_out[27:7] !== {7'h79, 7'h24, 7'h30}) begin
        bad++; $display("FAIL blink_steady_c%0d: got %h want %h", k, hex_out[27:7], {7'h79, 7'h24, 7'h30});
      end
      run++;
      if (hex_out[6:0] !== last) begin
        if (changes > 0) begin
          total++;
          if (run != 4) begin bad++; $display("FAIL blink_period: got %0d want 4", run); end
        end
        changes++; run = 0; last = hex_out[6:0];
      end
    end
    total++;
    if (changes < 4) begin bad++; $display("FAIL blink_toggles: got %0d want >=4", changes); end
    blink_en = 4'h0;
  endtask

  task automatic test_back_to_back();
    load_one(16'hAAAA, 1'b0, "b2b");
    load_valid = 1'b1; load_data = 16'h5555; load_blank_lz = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (load_ready !== (k == 5)) begin bad++; $display("FAIL b2b_ready_c%0d: got %b want %b", k, load_ready, (k == 5)); end
      total++;
      if (hex_out !== exp_hex()) begin bad++; $display("FAIL b2b_model_c%0d: got %h want %h", k, hex_out, exp_hex()); end
      @(negedge clk);
    end
    load_valid = 1'b0;
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept: got %b want 0", load_ready); end
    repeat (4) @(negedge clk);
    total++;
    if (hex_out !== {4{7'h12}}) begin bad++; $display("FAIL b2b_final: got %h want %h", hex_out, {4{7'h12}}); end
  endtask

  task automatic test_reset_mid_scan();
    load_one(16'h0000, 1'b0, "mid0");
    repeat (N) @(negedge clk);
    load_one(16'hFFFF, 1'b0, "mid1");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (hex_out !== 28'hFFFFFFF) begin bad++; $display("FAIL mid_blank: got %h want fffffff", hex_out); end
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", load_ready); end
    @(negedge clk);
    load_one(16'h0001, 1'b0, "mid2");
    repeat (N) @(negedge clk);
    total++;
    if (hex_out !== {7'h40, 7'h40, 7'h40, 7'h79}) begin
      bad++; $display("FAIL mid_reload: got %h want %h", hex_out, {7'h40, 7'h40, 7'h40, 7'h79});
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int k = 0; k < 400; k++) begin
      exp_rdy = rst ? 1'b0 : m_ready();
      total++;
      if (load_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready_c%0d: got %b want %b", k, load_ready, exp_rdy); end
      total++;
      if (hex_out !== exp_hex()) begin bad++; $display("FAIL rnd_hex_c%0d: got %h want %h", k, hex_out, exp_hex()); end
      rst           = ($urandom_range(0, 63) == 0);
      load_valid    = ($urandom_range(0, 2) == 0);
      load_data     = (($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom) >> (4 * $urandom_range(0, 3)));
      load_blank_lz = 1'($urandom);
      if ($urandom_range(0, 7) == 0) blink_en = 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; load_valid = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_blank_lz = 1'b0; blink_en = '0;
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_leading_zero();
    test_blink();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
